// File: rtl/ps2_controller.sv
// PS/2 device-to-host receiver.
// Runs entirely on the falling edge of the PS/2 clock line. It deframes
// start / 8 data (LSB first) / odd parity / stop, and hands each good byte to
// the consumer through a received flag that read_ack clears.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle, waiting for a 0 start bit
// DATA   | shifting in data bits 0..7
// PARITY | capturing the parity bit
// STOP   | sampling the stop bit; publish the byte if the frame is good
module ps2_controller #(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic       PS2_CLK,
    input  logic       rst,
    input  logic       read_ack,
    input  logic       PS2_DAT,
    output logic       received,
    output logic [7:0] received_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] bit_count;
    logic [7:0] shift_reg;
    logic       parity_bit;
    logic       frame_ok;

    // A frame is good at the stop-bit edge when the stop bit is 1 and the
    // parity is odd; odd parity is not required when CHECK_PARITY is 0.
    assign frame_ok = (state == STOP) && PS2_DAT &&
                      (!CHECK_PARITY || ((^shift_reg) ^ parity_bit));

    // Frame deserialiser and consumer handshake; a new byte wins over a
    // coincident ack so it is never lost.
    always_ff @(negedge PS2_CLK or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bit_count     <= 3'd0;
            shift_reg     <= 8'h00;
            parity_bit    <= 1'b0;
            received      <= 1'b0;
            received_data <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (!PS2_DAT) begin
                        state     <= DATA;
                        bit_count <= 3'd0;
                    end
                end
                DATA: begin
                    shift_reg[bit_count] <= PS2_DAT;
                    bit_count            <= bit_count + 3'd1;
                    if (bit_count == 3'd7) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    parity_bit <= PS2_DAT;
                    state      <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                    if (frame_ok) begin
                        received_data <= shift_reg;
                    end
                end
                default: state <= IDLE;
            endcase

            if (frame_ok) begin
                received <= 1'b1;
            end else if (read_ack) begin
                received <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_controller.sv
// Testbench for ps2_controller: two instances (parity checked / ignored)
// driven with the same directed and randomized frames. A frame-level
// reference model predicts the received flag and the latched byte.
module tb_ps2_controller;

    logic       PS2_CLK;
    logic       rst;
    logic       read_ack;
    logic       PS2_DAT;
    logic       received_p;
    logic [7:0] received_data_p;
    logic       received_n;
    logic [7:0] received_data_n;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: index 0 = parity-checking instance, 1 = parity-ignoring.
    logic       exp_recv [2];
    logic [7:0] exp_data [2];

    ps2_controller #(.CHECK_PARITY(1'b1)) dut_p (
        .PS2_CLK       (PS2_CLK),
        .rst           (rst),
        .read_ack      (read_ack),
        .PS2_DAT       (PS2_DAT),
        .received      (received_p),
        .received_data (received_data_p)
    );

    ps2_controller #(.CHECK_PARITY(1'b0)) dut_n (
        .PS2_CLK       (PS2_CLK),
        .rst           (rst),
        .read_ack      (read_ack),
        .PS2_DAT       (PS2_DAT),
        .received      (received_n),
        .received_data (received_data_n)
    );

    initial begin
        PS2_CLK = 1'b1;
        forever #5 PS2_CLK = ~PS2_CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " recv_p"}, {7'd0, received_p}, {7'd0, exp_recv[0]});
        check({tag, " data_p"}, received_data_p, exp_data[0]);
        check({tag, " recv_n"}, {7'd0, received_n}, {7'd0, exp_recv[1]});
        check({tag, " data_n"}, received_data_n, exp_data[1]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_recv[k] = 1'b0;
            exp_data[k] = 8'h00;
        end
    endtask

    // Idle line for n edges, optionally acking on each one.
    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) begin
            @(posedge PS2_CLK);
            PS2_DAT  = 1'b1;
            read_ack = ack;
            @(negedge PS2_CLK);
            #1;
            if (ack) begin
                exp_recv[0] = 1'b0;
                exp_recv[1] = 1'b0;
            end
        end
        check_all("idle");
        @(posedge PS2_CLK);
        read_ack = 1'b0;
    endtask

    // Send one frame; read_ack is high only on edge ack_edge (0 = start edge,
    // 10 = stop edge, -1 = never).
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int ack_edge);
        logic [10:0] bits;
        logic        valid [2];
        bits = {stp, par, d, 1'b0};
        valid[0] = stp && ((^d) ^ par);
        valid[1] = stp;
        for (int i = 0; i < 11; i++) begin
            @(posedge PS2_CLK);
            PS2_DAT  = bits[i];
            read_ack = (i == ack_edge);
            @(negedge PS2_CLK);
            #1;
            if (i == 9) begin
                if (ack_edge >= 0 && ack_edge <= 9) begin
                    exp_recv[0] = 1'b0;
                    exp_recv[1] = 1'b0;
                end
                check_all("pre-stop");
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (valid[k]) begin
                exp_data[k] = d;
                exp_recv[k] = 1'b1;
            end else if (ack_edge == 10) begin
                exp_recv[k] = 1'b0;
            end
        end
        check_all("stop");
        @(posedge PS2_CLK);
        read_ack = 1'b0;
        PS2_DAT  = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        logic       par;
        logic       stp;
        int         ack_edge;

        rst      = 1'b1;
        read_ack = 1'b0;
        PS2_DAT  = 1'b1;
        model_reset();
        repeat (2) @(negedge PS2_CLK);
        #1;
        check_all("reset");
        @(posedge PS2_CLK);
        rst = 1'b0;
        idle(3, 1'b0);

        // Directed frames.
        send_frame(8'h55, 1'b1, 1'b1, -1);
        idle(1, 1'b1);
        send_frame(8'hD3, 1'b0, 1'b1, -1);
        idle(1, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, -1);   // bad parity
        idle(1, 1'b1);
        send_frame(8'hA7, ~^8'hA7, 1'b0, -1); // framing error
        idle(2, 1'b0);
        send_frame(8'h81, ~^8'h81, 1'b1, -1);
        send_frame(8'h7E, ~^8'h7E, 1'b1, -1); // overwrite while unread
        send_frame(8'h12, ~^8'h12, 1'b1, 10); // ack on the stop edge
        send_frame(8'h34, ~^8'h34, 1'b0, 10); // ack on a dropped stop edge

        // Reset in the middle of a frame, then a clean frame.
        for (int i = 0; i < 5; i++) begin
            @(posedge PS2_CLK);
            PS2_DAT = (i == 0) ? 1'b0 : i[0];
            @(negedge PS2_CLK);
        end
        @(posedge PS2_CLK);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge PS2_CLK);
        #1;
        check_all("mid-rst");
        @(posedge PS2_CLK);
        rst     = 1'b0;
        PS2_DAT = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, -1);

        // Randomized frames.
        for (int f = 0; f < 60; f++) begin
            d        = 8'($urandom);
            par      = ($urandom_range(0, 3) == 0) ? ~(~^d) : ~^d;
            stp      = ($urandom_range(0, 5) != 0);
            ack_edge = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 10));
            send_frame(d, par, stp, ack_edge);
            idle(int'($urandom_range(1, 3)), 1'($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
